// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter: round-robin, packet-atomic sharing of one FIFO write port among N requesters.
// Define FIFO_ARB_MAX_BEATS_EN to force-release a grant after MAX_BEATS beats without last.
module fifo_wr_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic [W-1:0]         wr_data,
    output logic                 wr_en,
    input  logic                 wr_full,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 overrun
);
    localparam int GW = $clog2(N);
    typedef enum logic {ARB, XFER} state_t;
    state_t state;
    logic [GW-1:0] last_r, nxt, idx;
    logic [N-1:0][W-1:0] data_v;
    logic xfer, done, force_rel, found;

    if (N < 2 || N > 16 || MAX_BEATS < 1) begin : g_bad_cfg
        $error("fifo_wr_rr_arbiter: N must be 2..16 and MAX_BEATS >= 1");
    end

    assign data_v    = req_data;
    assign xfer      = state == XFER;
    assign busy      = xfer;
    assign req_ready = (xfer && !wr_full) ? N'(1) << grant_id : '0;
    assign wr_en     = xfer && req_valid[grant_id] && !wr_full;
    assign wr_data   = xfer ? data_v[grant_id] : '0;
    assign done      = wr_en && req_last[grant_id];

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        nxt = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(last_r) + k) % N);
            if (!found && req_valid[idx]) begin
                nxt = idx;
                found = 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_MAX_BEATS_EN
    localparam int CW = $clog2(MAX_BEATS + 1);
    logic [CW-1:0] beats;
    assign force_rel = wr_en && !req_last[grant_id] && beats == CW'(MAX_BEATS - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            beats   <= '0;
            overrun <= 1'b0;
        end else begin
            beats   <= xfer ? beats + CW'(wr_en) : '0;
            overrun <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign overrun   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            grant_id <= '0;
            last_r   <= GW'(N - 1);
        end else if (!xfer) begin
            if (found) begin
                grant_id <= nxt;
                state    <= XFER;
            end
        end else if (done || force_rel) begin
            last_r <= grant_id;
            state  <= ARB;
        end
    end
endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// tb_fifo_wr_rr_arbiter: table-driven directed checks of the round-robin FIFO write arbiter.
module tb_fifo_wr_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic [7:0]  wr_data;
    logic        wr_en, wr_full, busy, overrun;
    logic [1:0]  grant_id;
    int errors = 0;
    int checks = 0;

    fifo_wr_rr_arbiter #(.N(4), .W(8), .MAX_BEATS(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(wr_full), .grant_id(grant_id), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        f;
        logic [3:0]  rdy;
        logic        en;
        logic [7:0]  wd;
        logic [1:0]  g;
        logic        b;
    } vec_t;
    vec_t vq[$];

    localparam logic [31:0] D_RR = 32'h13121110;

    task automatic add(input logic rst, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic f, input logic [3:0] rdy,
                       input logic en, input logic [7:0] wd, input logic [1:0] g, input logic b);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.l = l; t.f = f;
        t.rdy = rdy; t.en = en; t.wd = wd; t.g = g; t.b = b;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic f);
        reset = rst; req_valid = v; req_data = d; req_last = l; wr_full = f;
    endtask

    initial begin
        drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // reset state
        add(1, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, 8'h00, 0, 0);
        // all valid, 1-beat packets: grants 0,1,2,3,0 with an idle cycle between
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h1, 1, 8'h10, 0, 1);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h2, 1, 8'h11, 1, 1);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h0, 0, 8'h00, 1, 0);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h4, 1, 8'h12, 2, 1);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h0, 0, 8'h00, 2, 0);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h8, 1, 8'h13, 3, 1);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h0, 0, 8'h00, 3, 0);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h1, 1, 8'h10, 0, 1);
        // requester 2 three-beat packet while requester 0 waits
        add(0, 4'h5, 32'h00A10010, 4'h1, 0, 4'h0, 0, 8'h00, 0, 0);
        add(0, 4'h5, 32'h00A10010, 4'h1, 0, 4'h4, 1, 8'hA1, 2, 1);
        add(0, 4'h5, 32'h00A20010, 4'h1, 0, 4'h4, 1, 8'hA2, 2, 1);
        add(0, 4'h5, 32'h00A30010, 4'h5, 0, 4'h4, 1, 8'hA3, 2, 1);
        add(0, 4'h1, 32'h00000010, 4'h1, 0, 4'h0, 0, 8'h00, 2, 0);
        add(0, 4'h1, 32'h00000010, 4'h1, 0, 4'h1, 1, 8'h10, 0, 1);
        // wr_full for 5 cycles mid-packet from requester 1
        add(0, 4'h2, 32'h0000B100, 4'h0, 0, 4'h0, 0, 8'h00, 0, 0);
        add(0, 4'h2, 32'h0000B100, 4'h0, 0, 4'h2, 1, 8'hB1, 1, 1);
        for (int i = 0; i < 5; i++) add(0, 4'h2, 32'h0000B200, 4'h0, 1, 4'h0, 0, 8'hB2, 1, 1);
        add(0, 4'h2, 32'h0000B200, 4'h0, 0, 4'h2, 1, 8'hB2, 1, 1);
        add(0, 4'h2, 32'h0000B300, 4'h2, 0, 4'h2, 1, 8'hB3, 1, 1);
        add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, 8'h00, 1, 0);
        // owner 2 drops valid for 3 cycles while 0 and 3 request
        add(0, 4'hD, 32'h33C10030, 4'h9, 0, 4'h0, 0, 8'h00, 1, 0);
        add(0, 4'hD, 32'h33C10030, 4'h9, 0, 4'h4, 1, 8'hC1, 2, 1);
        for (int i = 0; i < 3; i++) add(0, 4'h9, 32'h33C20030, 4'h9, 0, 4'h4, 0, 8'hC2, 2, 1);
        add(0, 4'hD, 32'h33C20030, 4'hD, 0, 4'h4, 1, 8'hC2, 2, 1);
        add(0, 4'h9, 32'h33000030, 4'h9, 0, 4'h0, 0, 8'h00, 2, 0);
        add(0, 4'h9, 32'h33000030, 4'h9, 0, 4'h8, 1, 8'h33, 3, 1);
        add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, 8'h00, 3, 0);
        // reset during beat 2 of a 4-beat packet from requester 1
        add(0, 4'h2, 32'h0000D100, 4'h0, 0, 4'h0, 0, 8'h00, 3, 0);
        add(0, 4'h2, 32'h0000D100, 4'h0, 0, 4'h2, 1, 8'hD1, 1, 1);
        add(1, 4'h2, 32'h0000D200, 4'h0, 0, 4'h2, 1, 8'hD2, 1, 1);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0);
        add(0, 4'hF, D_RR, 4'hF, 0, 4'h1, 1, 8'h10, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].v, vq[i].d, vq[i].l, vq[i].f);
            @(negedge clk);
            chk("req_ready", i, 32'(req_ready), 32'(vq[i].rdy));
            chk("wr_en", i, 32'(wr_en), 32'(vq[i].en));
            chk("wr_data", i, 32'(wr_data), 32'(vq[i].wd));
            chk("grant_id", i, 32'(grant_id), 32'(vq[i].g));
            chk("busy", i, 32'(busy), 32'(vq[i].b));
            chk("overrun", i, 32'(overrun), 32'h0);
            @(posedge clk);
            #1;
        end

`ifdef FIFO_ARB_MAX_BEATS_EN
        // 6-beat packet from requester 3 with MAX_BEATS=4: forced release after beat 4
        drive(1'b0, 4'h8, 32'hE1000000, 4'h0, 1'b0);
        @(negedge clk);
        chk("mb_arb_busy", 100, 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        for (int b = 1; b <= 4; b++) begin
            req_data = {8'(8'hE0 + b), 24'h0};
            @(negedge clk);
            chk("mb_wr_en", 100 + b, 32'(wr_en), 32'h1);
            chk("mb_grant", 100 + b, 32'(grant_id), 32'h3);
            chk("mb_wr_data", 100 + b, 32'(wr_data), 32'hE0 + b);
            chk("mb_overrun", 100 + b, 32'(overrun), 32'h0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 4'h9, 32'hE5000030, 4'h1, 1'b0);
        @(negedge clk);
        chk("mb_overrun_pulse", 105, 32'(overrun), 32'h1);
        chk("mb_release_busy", 105, 32'(busy), 32'h0);
        chk("mb_release_wr_en", 105, 32'(wr_en), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mb_overrun_clear", 106, 32'(overrun), 32'h0);
        chk("mb_next_grant", 106, 32'(grant_id), 32'h0);
        chk("mb_next_wr_data", 106, 32'(wr_data), 32'h30);
        @(posedge clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
